// File: rtl/univ_shift_seq_if.sv
// rtl/univ_shift_seq_if.sv - control/data bundle for the universal shift/sequence register
// The master side drives steps and data; the slave side is the register itself.
interface univ_shift_seq_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic [2:0]       MODE;
  logic             DSR;
  logic             DSL;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             SO_R;
  logic             SO_L;
  logic             WRAP;
  logic             SEQ_ERR;

  modport master (
    output EN, MODE, DSR, DSL, D,
    input  Q, SO_R, SO_L, WRAP, SEQ_ERR
  );

  modport slave (
    input  EN, MODE, DSR, DSL, D,
    output Q, SO_R, SO_L, WRAP, SEQ_ERR
  );
endinterface

// File: rtl/univ_shift_seq.sv
// rtl/univ_shift_seq.sv - WIDTH-bit 194-style shift register with self-correcting ring/Johnson modes
// WRAP and SEQ_ERR are registered alongside Q so all three describe the same step.
module univ_shift_seq #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          CLK,
  input  logic          CLRn,
  univ_shift_seq_if.slave bus
);
  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHR   = 3'b001,
    M_SHL   = 3'b010,
    M_LOAD  = 3'b011,
    M_RINGR = 3'b100,
    M_RINGL = 3'b101,
    M_JOHNR = 3'b110,
    M_JOHNL = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] RING_START = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             err_r;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic [WIDTH-2:0] edges;
  logic             ring_ok;
  logic             john_ok;
  mode_e            mode;

  assign mode  = mode_e'(bus.MODE);
  // A legal Johnson word has at most one boundary between adjacent bits.
  assign edges   = q_r[WIDTH-2:0] ^ q_r[WIDTH-1:1];
  assign john_ok = (edges & (edges - 1'b1)) == '0;
  assign ring_ok = (q_r != '0) && ((q_r & (q_r - 1'b1)) == '0);

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (bus.EN) begin
      unique case (mode)
        M_HOLD: q_nxt = q_r;
        M_SHR:  q_nxt = {bus.DSR, q_r[WIDTH-1:1]};
        M_SHL:  q_nxt = {q_r[WIDTH-2:0], bus.DSL};
        M_LOAD: q_nxt = bus.D;
        M_RINGR, M_RINGL: begin
          if (!ring_ok) begin
            q_nxt   = RING_START;
            err_nxt = 1'b1;
          end else begin
            q_nxt    = (mode == M_RINGR) ? {q_r[0], q_r[WIDTH-1:1]}
                                         : {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            wrap_nxt = (q_nxt == RING_START);
          end
        end
        M_JOHNR, M_JOHNL: begin
          if (!john_ok) begin
            q_nxt   = '0;
            err_nxt = 1'b1;
          end else begin
            q_nxt    = (mode == M_JOHNR) ? {~q_r[0], q_r[WIDTH-1:1]}
                                         : {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
            wrap_nxt = (q_nxt == '0);
          end
        end
        default: q_nxt = q_r;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      q_r    <= RESET_VAL;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
      err_r  <= err_nxt;
    end
  end

  assign bus.Q       = q_r;
  assign bus.SO_R    = q_r[0];
  assign bus.SO_L    = q_r[WIDTH-1];
  assign bus.WRAP    = wrap_r;
  assign bus.SEQ_ERR = err_r;
endmodule

// File: tb/tb_univ_shift_seq.sv
// tb/tb_univ_shift_seq.sv - bench for univ_shift_seq at WIDTH 8 and WIDTH 4
// A word-level model tracks both instances; directed steps also carry literal expectations.
module tb_univ_shift_seq;
  logic CLK = 1'b0;
  logic CLRn = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic cmp_on = 1'b0;

  always #5 CLK = ~CLK;

  univ_shift_seq_if #(.WIDTH(8)) b8 ();
  univ_shift_seq_if #(.WIDTH(4)) b4 ();

  univ_shift_seq #(.WIDTH(8)) u8 (.CLK(CLK), .CLRn(CLRn), .bus(b8.slave));
  univ_shift_seq #(.WIDTH(4)) u4 (.CLK(CLK), .CLRn(CLRn), .bus(b4.slave));

  logic [31:0] m8_q, m4_q;
  logic        m8_w, m8_e, m4_w, m4_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Next state straight from the mode table, using plain word arithmetic.
  function automatic void mstep(input logic [31:0] q, input int w, input logic en,
                                input logic [2:0] mode, input logic dsr, input logic dsl,
                                input logic [31:0] d, output logic [31:0] nq,
                                output logic wrap, output logic err);
    logic [31:0] mask;
    logic [31:0] top;
    int          trans;
    mask  = (32'd1 << w) - 32'd1;
    top   = 32'd1 << (w - 1);
    trans = 0;
    nq    = q;
    wrap  = 1'b0;
    err   = 1'b0;
    if (en) begin
      case (mode)
        3'd1: nq = (q >> 1) | (dsr ? top : 32'd0);
        3'd2: nq = ((q << 1) | {31'd0, dsl}) & mask;
        3'd3: nq = d & mask;
        3'd4, 3'd5: begin
          if ($countones(q) != 1) begin
            nq  = 32'd1;
            err = 1'b1;
          end else begin
            if (mode == 3'd4) nq = (q == 32'd1) ? top : (q >> 1);
            else              nq = (q == top) ? 32'd1 : (q << 1);
            wrap = (nq == 32'd1);
          end
        end
        3'd6, 3'd7: begin
          for (int i = 0; i < w - 1; i++) if (q[i] != q[i+1]) trans++;
          if (trans > 1) begin
            nq  = 32'd0;
            err = 1'b1;
          end else begin
            if (mode == 3'd6) nq = (q >> 1) | ((q & 32'd1) == 32'd0 ? top : 32'd0);
            else              nq = ((q << 1) | ((q & top) == 32'd0 ? 32'd1 : 32'd0)) & mask;
            wrap = (nq == 32'd0);
          end
        end
        default: nq = q;
      endcase
    end
  endfunction

  always @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      m8_q = 32'd0; m8_w = 1'b0; m8_e = 1'b0;
      m4_q = 32'd0; m4_w = 1'b0; m4_e = 1'b0;
    end else begin
      mstep(m8_q, 8, b8.EN, b8.MODE, b8.DSR, b8.DSL, 32'(b8.D), m8_q, m8_w, m8_e);
      mstep(m4_q, 4, b4.EN, b4.MODE, b4.DSR, b4.DSL, 32'(b4.D), m4_q, m4_w, m4_e);
    end
  end

  always @(negedge CLK) begin
    if (cmp_on) begin
      chk("model_q8",    32'(b8.Q),       m8_q);
      chk("model_wrap8", 32'(b8.WRAP),    32'(m8_w));
      chk("model_err8",  32'(b8.SEQ_ERR), 32'(m8_e));
      chk("model_sor8",  32'(b8.SO_R),    32'(m8_q[0]));
      chk("model_sol8",  32'(b8.SO_L),    32'(m8_q[7]));
      chk("model_q4",    32'(b4.Q),       m4_q);
      chk("model_wrap4", 32'(b4.WRAP),    32'(m4_w));
      chk("model_err4",  32'(b4.SEQ_ERR), 32'(m4_e));
    end
  end

  task automatic drv8(input logic en, input logic [2:0] mode, input logic dsr,
                      input logic dsl, input logic [7:0] d);
    @(negedge CLK);
    b8.EN = en; b8.MODE = mode; b8.DSR = dsr; b8.DSL = dsl; b8.D = d;
    b4.EN = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic drv4(input logic en, input logic [2:0] mode, input logic [3:0] d);
    @(negedge CLK);
    b4.EN = en; b4.MODE = mode; b4.DSR = 1'b0; b4.DSL = 1'b0; b4.D = d;
    b8.EN = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] john_seq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                               4'b0111, 4'b0011, 4'b0001, 4'b0000};

  initial begin
    b8.EN = 1'b0; b8.MODE = 3'd0; b8.DSR = 1'b0; b8.DSL = 1'b0; b8.D = 8'h00;
    b4.EN = 1'b0; b4.MODE = 3'd0; b4.DSR = 1'b0; b4.DSL = 1'b0; b4.D = 4'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_q8", 32'(b8.Q), 32'h00);
    chk("reset_wrap8", 32'(b8.WRAP), 32'd0);
    chk("reset_err8", 32'(b8.SEQ_ERR), 32'd0);
    @(negedge CLK);
    CLRn = 1'b1;
    cmp_on = 1'b1;

    // load then shift
    drv8(1'b1, 3'd3, 1'b0, 1'b0, 8'h81); chk("load_81", 32'(b8.Q), 32'h81);
    drv8(1'b1, 3'd1, 1'b1, 1'b0, 8'h00); chk("shr_c0", 32'(b8.Q), 32'hC0);
    drv8(1'b1, 3'd1, 1'b0, 1'b0, 8'h00); chk("shr_60", 32'(b8.Q), 32'h60);
    drv8(1'b1, 3'd2, 1'b0, 1'b1, 8'h00); chk("shl_c1", 32'(b8.Q), 32'hC1);
    drv8(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF); chk("hold_c1", 32'(b8.Q), 32'hC1);

    // ring right full period
    drv8(1'b1, 3'd3, 1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 8; i++) begin
      drv8(1'b1, 3'd4, 1'b0, 1'b0, 8'h00);
      chk("ringr_q", 32'(b8.Q), 32'h80 >> i);
      chk("ringr_wrap", 32'(b8.WRAP), (i == 7) ? 32'd1 : 32'd0);
    end

    // enable gap mid ring
    drv8(1'b1, 3'd4, 1'b0, 1'b0, 8'h00);
    drv8(1'b1, 3'd4, 1'b0, 1'b0, 8'h00);
    chk("ring_pre_gap", 32'(b8.Q), 32'h40);
    for (int i = 0; i < 3; i++) begin
      drv8(1'b0, 3'd4, 1'b0, 1'b0, 8'h00);
      chk("gap_q", 32'(b8.Q), 32'h40);
      chk("gap_pulse", 32'({b8.WRAP, b8.SEQ_ERR}), 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      drv8(1'b1, 3'd4, 1'b0, 1'b0, 8'h00);
      chk("resume_q", 32'(b8.Q), 32'h20 >> i);
    end
    chk("resume_wrap", 32'(b8.WRAP), 32'd1);

    // ring correction and recovery
    drv8(1'b1, 3'd3, 1'b0, 1'b0, 8'h00);
    drv8(1'b1, 3'd5, 1'b0, 1'b0, 8'h00);
    chk("ringl_fix_q", 32'(b8.Q), 32'h01);
    chk("ringl_fix_err", 32'(b8.SEQ_ERR), 32'd1);
    chk("ringl_fix_wrap", 32'(b8.WRAP), 32'd0);
    drv8(1'b1, 3'd5, 1'b0, 1'b0, 8'h00);
    chk("ringl_q", 32'(b8.Q), 32'h02);
    chk("ringl_err", 32'(b8.SEQ_ERR), 32'd0);

    // Johnson right, W=4, from reset value
    for (int i = 0; i < 8; i++) begin
      drv4(1'b1, 3'd6, 4'h0);
      chk("johnr_q", 32'(b4.Q), 32'(john_seq[i]));
      chk("johnr_wrap", 32'(b4.WRAP), (i == 7) ? 32'd1 : 32'd0);
      chk("johnr_err", 32'(b4.SEQ_ERR), 32'd0);
    end
    drv4(1'b1, 3'd7, 4'h0); chk("johnl_q", 32'(b4.Q), 32'h1);
    drv4(1'b1, 3'd3, 4'b0101);
    drv4(1'b1, 3'd7, 4'h0);
    chk("johnl_fix_q", 32'(b4.Q), 32'h0);
    chk("johnl_fix_err", 32'(b4.SEQ_ERR), 32'd1);
    chk("johnl_fix_wrap", 32'(b4.WRAP), 32'd0);

    // mode changes every cycle, including an invalid ring start
    drv8(1'b1, 3'd3, 1'b0, 1'b0, 8'hA5);
    drv8(1'b1, 3'd4, 1'b0, 1'b0, 8'h00);
    chk("ring_a5_fix", 32'(b8.Q), 32'h01);
    drv8(1'b1, 3'd7, 1'b0, 1'b0, 8'h00); chk("mix_johnl", 32'(b8.Q), 32'h03);
    drv8(1'b1, 3'd1, 1'b1, 1'b0, 8'h00); chk("mix_shr", 32'(b8.Q), 32'h81);

    // asynchronous reset mid-run
    drv8(1'b1, 3'd3, 1'b0, 1'b0, 8'hA5);
    chk("pre_reset", 32'(b8.Q), 32'hA5);
    #3;
    CLRn = 1'b0;
    #1;
    chk("async_q", 32'(b8.Q), 32'h00);
    chk("async_pulses", 32'({b8.WRAP, b8.SEQ_ERR}), 32'd0);
    @(negedge CLK);
    CLRn = 1'b1;
    drv8(1'b1, 3'd4, 1'b0, 1'b0, 8'h00);
    chk("post_reset_q", 32'(b8.Q), 32'h01);
    chk("post_reset_err", 32'(b8.SEQ_ERR), 32'd1);

    @(negedge CLK);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
